// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel, W-bit registered stream multiplexer.
// An internal round-robin or fixed-priority arbiter picks the source channel.
// A single output register supports accept-while-drain, so the sustained
// rate is one beat per cycle. in_ready is combinational from out_ready.
module rr_stream_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fixed_pri,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);
    // The scan index needs one extra bit so rr_ptr + offset cannot overflow
    // before the modulo-NCH fold.
    localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH-1);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             load_en;
    logic             take;
    logic             gnt_found;
    logic [SELW-1:0]  gnt_idx;
    logic [SELW:0]    scan_idx;
    logic [WIDTH-1:0] ch_data [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Arbiter: loops run from the far end down, so the last hit written is
    // the first channel in scan order (lowest index, or nearest to rr_ptr).
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        if (fixed_pri) begin
            for (int i = NCH-1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SELW'(i);
                end
            end
        end else begin
            for (int k = NCH-1; k >= 0; k--) begin
                scan_idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
                if (scan_idx >= NCH_W) begin
                    scan_idx = scan_idx - NCH_W;
                end
                if (in_valid[scan_idx[SELW-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = scan_idx[SELW-1:0];
                end
            end
        end
    end

    // Handshake and next-state: load when empty or draining, hold under backpressure.
    always_comb begin
        load_en  = !out_valid_q || out_ready;
        take     = gnt_found && load_en && !reset;
        in_ready = '0;
        if (take) begin
            in_ready[gnt_idx] = 1'b1;
        end
        out_valid_d = take || (out_valid_q && !out_ready);
        out_data_d  = take ? ch_data[gnt_idx] : out_data_q;
        out_ch_d    = take ? gnt_idx : out_ch_q;
        if (take) begin
            rr_ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SELW'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Output register and round-robin pointer; reset drops any held beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed stimulus with a scoreboard. The stimulus block
// pushes hand-computed beats and per-cycle ready/state expectations; the
// monitor compares them on the falling edge.
module tb_rr_stream_mux;
    logic clk = 1'b0;
    logic reset;
    logic fixed_pri;

    // 4-channel instance
    logic [3:0]  in_valid4, in_ready4, exp_rdy4;
    logic [31:0] in_data4;
    logic        out_valid4, out_ready4;
    logic [7:0]  out_data4;
    logic [1:0]  out_ch4;

    // 3-channel instance for the non-power-of-two wrap
    logic [2:0]  in_valid3, in_ready3, exp_rdy3;
    logic [23:0] in_data3;
    logic        out_valid3, out_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } beat_t;

    beat_t q4[$];
    beat_t q3[$];

    logic       chk_st;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [1:0] exp_c;
    logic       done;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] dat4 [4] = '{8'hA5, 8'hB1, 8'hC2, 8'hD3};

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(8), .NCH(4), .SELW(2)) u_dut4 (
        .clk(clk), .reset(reset), .fixed_pri(fixed_pri),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
        .out_ready(out_ready4)
    );

    rr_stream_mux #(.WIDTH(8), .NCH(3), .SELW(2)) u_dut3 (
        .clk(clk), .reset(reset), .fixed_pri(1'b0),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    // Monitor: all comparisons happen here, away from the rising edge.
    always @(negedge clk) begin
        beat_t b;
        if (chk_st) begin
            nvec++;
            if ({out_valid4, out_data4, out_ch4} !== {exp_v, exp_d, exp_c}) begin
                nerr++;
                $display("FAIL state4 @%0t: got v=%0b d=%h ch=%0d, want v=%0b d=%h ch=%0d",
                         $time, out_valid4, out_data4, out_ch4, exp_v, exp_d, exp_c);
            end
        end
        nvec++;
        if (in_ready4 !== exp_rdy4) begin
            nerr++;
            $display("FAIL in_ready4 @%0t: got %b want %b", $time, in_ready4, exp_rdy4);
        end
        nvec++;
        if (in_ready3 !== exp_rdy3) begin
            nerr++;
            $display("FAIL in_ready3 @%0t: got %b want %b", $time, in_ready3, exp_rdy3);
        end
        if (!reset && out_valid4 && out_ready4) begin
            nvec++;
            if (q4.size() == 0) begin
                nerr++;
                $display("FAIL beat4 @%0t: unexpected beat ch=%0d d=%h", $time, out_ch4, out_data4);
            end else begin
                b = q4.pop_front();
                if ({out_ch4, out_data4} !== b) begin
                    nerr++;
                    $display("FAIL beat4 @%0t: got ch=%0d d=%h want ch=%0d d=%h",
                             $time, out_ch4, out_data4, b.ch, b.data);
                end
            end
        end
        if (!reset && out_valid3 && out_ready3) begin
            nvec++;
            if (q3.size() == 0) begin
                nerr++;
                $display("FAIL beat3 @%0t: unexpected beat ch=%0d d=%h", $time, out_ch3, out_data3);
            end else begin
                b = q3.pop_front();
                if ({out_ch3, out_data3} !== b) begin
                    nerr++;
                    $display("FAIL beat3 @%0t: got ch=%0d d=%h want ch=%0d d=%h",
                             $time, out_ch3, out_data3, b.ch, b.data);
                end
            end
        end
        if (done) begin
            nvec++;
            if (q4.size() != 0 || q3.size() != 0) begin
                nerr++;
                $display("FAIL drain: beats left q4=%0d q3=%0d, want 0 0", q4.size(), q3.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
            $finish;
        end
    end

    // One cycle of stimulus; u_dut3 inputs default to idle.
    task automatic cyc(input logic [3:0] v, input logic ordy, input logic [3:0] er);
        @(posedge clk);
        #1;
        in_valid4 = v;
        out_ready4 = ordy;
        exp_rdy4 = er;
        in_valid3 = '0;
        exp_rdy3 = '0;
        chk_st = 1'b0;
    endtask

    task automatic expect_st(input logic v, input logic [7:0] d, input logic [1:0] c);
        chk_st = 1'b1;
        exp_v = v;
        exp_d = d;
        exp_c = c;
    endtask

    task automatic push4(input logic [1:0] c, input logic [7:0] d);
        q4.push_back({c, d});
    endtask

    task automatic push3(input logic [1:0] c, input logic [7:0] d);
        q3.push_back({c, d});
    endtask

    task automatic do_reset();
        cyc(4'h0, 1'b1, 4'h0);
        reset = 1'b1;
        cyc(4'h0, 1'b1, 4'h0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        fixed_pri = 1'b0;
        done = 1'b0;
        chk_st = 1'b0;
        exp_v = 1'b0;
        exp_d = '0;
        exp_c = '0;
        in_data4 = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
        in_data3 = {8'h33, 8'h22, 8'h11};
        // All sources valid during reset: no channel may be acknowledged
        in_valid4 = 4'hF;
        in_valid3 = 3'h7;
        out_ready4 = 1'b1;
        out_ready3 = 1'b1;
        exp_rdy4 = '0;
        exp_rdy3 = '0;
        repeat (2) @(posedge clk);

        // Reset state
        cyc(4'h0, 1'b1, 4'h0);
        reset = 1'b0;
        expect_st(1'b0, 8'h00, 2'd0);

        // Single beat from ch0, one cycle latency
        cyc(4'b0001, 1'b1, 4'b0001);
        push4(2'd0, 8'hA5);
        cyc(4'h0, 1'b1, 4'h0);
        expect_st(1'b1, 8'hA5, 2'd0);
        // Idle cycles must not move rr_ptr (now 1)
        cyc(4'h0, 1'b1, 4'h0);
        cyc(4'h0, 1'b1, 4'h0);
        cyc(4'hF, 1'b1, 4'b0010);
        push4(2'd1, 8'hB1);
        cyc(4'h0, 1'b1, 4'h0);

        // Round-robin fairness at full rate
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(4'hF, 1'b1, 4'(1 << (i % 4)));
            push4(2'(i % 4), dat4[i % 4]);
        end
        cyc(4'h0, 1'b1, 4'h0);

        // Fixed priority: ch0 every beat; rr_ptr keeps tracking grants
        fixed_pri = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(4'hF, 1'b1, 4'b0001);
            push4(2'd0, 8'hA5);
        end
        cyc(4'h0, 1'b1, 4'h0);
        fixed_pri = 1'b0;
        cyc(4'hF, 1'b1, 4'b0010);
        push4(2'd1, 8'hB1);
        cyc(4'h0, 1'b1, 4'h0);

        // Backpressure while holding a ch2 beat
        do_reset();
        cyc(4'b0100, 1'b0, 4'b0100);
        push4(2'd2, 8'hC2);
        for (int i = 0; i < 5; i++) begin
            cyc(4'hF, 1'b0, 4'h0);
            expect_st(1'b1, 8'hC2, 2'd2);
        end
        cyc(4'hF, 1'b1, 4'b1000);
        push4(2'd3, 8'hD3);
        cyc(4'h0, 1'b1, 4'h0);
        cyc(4'h0, 1'b1, 4'h0);
        expect_st(1'b0, 8'hD3, 2'd3);

        // Reset while full discards the beat and rewinds rr_ptr
        in_data4[7:0] = 8'h5A;
        cyc(4'b0001, 1'b0, 4'b0001);
        cyc(4'h0, 1'b0, 4'h0);
        expect_st(1'b1, 8'h5A, 2'd0);
        cyc(4'h0, 1'b0, 4'h0);
        reset = 1'b1;
        cyc(4'h0, 1'b1, 4'h0);
        reset = 1'b0;
        expect_st(1'b0, 8'h00, 2'd0);
        in_data4[7:0] = 8'hA5;
        cyc(4'hF, 1'b1, 4'b0001);
        push4(2'd0, 8'hA5);
        cyc(4'h0, 1'b1, 4'h0);

        // NCH=3 wrap: ch2, then ch0 (pointer 2 -> 0), then ch2 again
        cyc(4'h0, 1'b1, 4'h0);
        in_valid3 = 3'b100;
        exp_rdy3 = 3'b100;
        push3(2'd2, 8'h33);
        cyc(4'h0, 1'b1, 4'h0);
        in_valid3 = 3'b101;
        exp_rdy3 = 3'b001;
        push3(2'd0, 8'h11);
        cyc(4'h0, 1'b1, 4'h0);
        in_valid3 = 3'b101;
        exp_rdy3 = 3'b100;
        push3(2'd2, 8'h33);
        cyc(4'h0, 1'b1, 4'h0);
        cyc(4'h0, 1'b1, 4'h0);
        done = 1'b1;
    end

endmodule
